// File: rtl/alu_pkg.sv
// Shared ALU encodings: ctl codes driven into the 32-bit alu, ALUOp classes and R-type funct values.
package alu_pkg;

  localparam logic [2:0] CTL_AND = 3'b000;
  localparam logic [2:0] CTL_OR  = 3'b001;
  localparam logic [2:0] CTL_ADD = 3'b010;
  localparam logic [2:0] CTL_SUB = 3'b110;
  localparam logic [2:0] CTL_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'd32;
  localparam logic [5:0] FUNCT_SUB = 6'd34;
  localparam logic [5:0] FUNCT_AND = 6'd36;
  localparam logic [5:0] FUNCT_OR  = 6'd37;
  localparam logic [5:0] FUNCT_SLT = 6'd42;

endpackage

// File: rtl/alu_ctl_dec.sv
// Combinational ALUOp/funct to ALU ctl translation; flags unsupported R-type funct values.
module alu_ctl_dec
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  input  logic       valid,
  output logic [2:0] ctl,
  output logic       illegal
);

  always_comb begin
    ctl     = CTL_ADD;
    illegal = 1'b0;
    unique case (aluop)
      ALUOP_ADD: ctl = CTL_ADD;
      ALUOP_SUB: ctl = CTL_SUB;
      ALUOP_OR:  ctl = CTL_OR;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: ctl = CTL_ADD;
          FUNCT_SUB: ctl = CTL_SUB;
          FUNCT_AND: ctl = CTL_AND;
          FUNCT_OR:  ctl = CTL_OR;
          FUNCT_SLT: ctl = CTL_SLT;
          // Unknown funct falls back to add; only a live instruction is flagged.
          default: begin
            ctl     = CTL_ADD;
            illegal = valid;
          end
        endcase
      end
      default: ctl = CTL_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU ctl decode, stall/flush and RAW operand forwarding.
// Forwarding muxes are built only when ID_EX_FORWARD_EN is defined.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [1:0]        id_aluop,
  input  logic [5:0]        id_funct,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_alusrc,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_regdst,
  input  logic              id_regwrite,
  input  logic              exm_regwrite,
  input  logic [4:0]        exm_wreg,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              mwb_regwrite,
  input  logic [4:0]        mwb_wreg,
  input  logic [DATA_W-1:0] mwb_result,
  output logic              ex_valid,
  output logic [2:0]        ctl,
  output logic [DATA_W-1:0] dataA,
  output logic [DATA_W-1:0] dataB,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [4:0]        ex_wreg,
  output logic              ex_regwrite,
  output logic              ex_illegal
);

  typedef struct packed {
    logic              valid;
    logic [2:0]        ctl;
    logic              illegal;
    logic [4:0]        wreg;
    logic              regwrite;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic              alusrc;
  } ex_regs_t;

  ex_regs_t   stage_q, stage_d, load, bubble;
  logic [2:0] dec_ctl;
  logic       dec_illegal;

  alu_ctl_dec u_alu_ctl_dec (
    .aluop   (id_aluop),
    .funct   (id_funct),
    .valid   (id_valid),
    .ctl     (dec_ctl),
    .illegal (dec_illegal)
  );

  always_comb begin
    bubble     = '0;
    bubble.ctl = CTL_ADD;

    load          = '0;
    load.valid    = id_valid;
    load.ctl      = dec_ctl;
    load.illegal  = dec_illegal;
    load.wreg     = id_regdst ? id_rd : id_rt;
    load.regwrite = id_regwrite & id_valid;
    load.rs       = id_rs;
    load.rt       = id_rt;
    load.rs_data  = id_rs_data;
    load.rt_data  = id_rt_data;
    load.imm      = id_imm;
    load.alusrc   = id_alusrc;

    // Flush outranks stall so a squashed instruction never lingers.
    stage_d = stage_q;
    if (flush) begin
      stage_d = bubble;
    end else if (!stall) begin
      stage_d = load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= bubble;
    end else begin
      stage_q <= stage_d;
    end
  end

  logic [DATA_W-1:0] fwd_rs, fwd_rt;

`ifdef ID_EX_FORWARD_EN
  // EX/MEM is the younger producer, so it is checked first; r0 is hardwired zero.
  always_comb begin
    fwd_rs = stage_q.rs_data;
    if (exm_regwrite && (exm_wreg != 5'd0) && (exm_wreg == stage_q.rs)) begin
      fwd_rs = exm_result;
    end else if (mwb_regwrite && (mwb_wreg != 5'd0) && (mwb_wreg == stage_q.rs)) begin
      fwd_rs = mwb_result;
    end
  end

  always_comb begin
    fwd_rt = stage_q.rt_data;
    if (exm_regwrite && (exm_wreg != 5'd0) && (exm_wreg == stage_q.rt)) begin
      fwd_rt = exm_result;
    end else if (mwb_regwrite && (mwb_wreg != 5'd0) && (mwb_wreg == stage_q.rt)) begin
      fwd_rt = mwb_result;
    end
  end
`else
  assign fwd_rs = stage_q.rs_data;
  assign fwd_rt = stage_q.rt_data;

  logic unused_fwd;
  assign unused_fwd = ^{exm_regwrite, exm_wreg, exm_result, mwb_regwrite, mwb_wreg, mwb_result,
                        stage_q.rs, stage_q.rt};
`endif

  assign ex_valid      = stage_q.valid;
  assign ctl           = stage_q.ctl;
  assign ex_illegal    = stage_q.illegal;
  assign ex_wreg       = stage_q.wreg;
  assign ex_regwrite   = stage_q.regwrite & stage_q.valid;
  assign dataA         = fwd_rs;
  assign dataB         = stage_q.alusrc ? stage_q.imm : fwd_rt;
  assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: decode table, directed corner sequences, random vs model.
module tb_id_ex_stage;

  localparam int DW = 32;
`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk, rst, stall, flush;
  logic          id_valid, id_alusrc, id_regdst, id_regwrite;
  logic [1:0]    id_aluop;
  logic [5:0]    id_funct;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic          exm_regwrite, mwb_regwrite;
  logic [4:0]    exm_wreg, mwb_wreg;
  logic [DW-1:0] exm_result, mwb_result;
  logic          ex_valid, ex_regwrite, ex_illegal;
  logic [2:0]    ctl;
  logic [DW-1:0] dataA, dataB, ex_store_data;
  logic [4:0]    ex_wreg;

  id_ex_stage #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_aluop(id_aluop), .id_funct(id_funct),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_regdst(id_regdst), .id_regwrite(id_regwrite),
    .exm_regwrite(exm_regwrite), .exm_wreg(exm_wreg), .exm_result(exm_result),
    .mwb_regwrite(mwb_regwrite), .mwb_wreg(mwb_wreg), .mwb_result(mwb_result),
    .ex_valid(ex_valid), .ctl(ctl), .dataA(dataA), .dataB(dataB),
    .ex_store_data(ex_store_data), .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite),
    .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Model of what the stage currently holds, in terms of the architectural fields.
  logic          m_valid, m_ill, m_rw, m_src;
  logic [2:0]    m_ctl;
  logic [4:0]    m_wreg, m_rs, m_rt;
  logic [DW-1:0] m_rsd, m_rtd, m_imm;

  // Returns {ctl, illegal} straight from the ALUOp/funct table.
  function automatic logic [3:0] ref_dec(input logic [1:0] op, input logic [5:0] fn,
                                         input logic v);
    int f;
    f = int'(fn);
    if (op == 2'd0) return {3'b010, 1'b0};
    if (op == 2'd1) return {3'b110, 1'b0};
    if (op == 2'd3) return {3'b001, 1'b0};
    if (f == 32) return {3'b010, 1'b0};
    if (f == 34) return {3'b110, 1'b0};
    if (f == 36) return {3'b000, 1'b0};
    if (f == 37) return {3'b001, 1'b0};
    if (f == 42) return {3'b111, 1'b0};
    return {3'b010, v};
  endfunction

  function automatic logic [DW-1:0] ref_fwd(input logic [4:0] r, input logic [DW-1:0] v);
    if (!FWD || r == 5'd0) return v;
    if (exm_regwrite && exm_wreg == r) return exm_result;
    if (mwb_regwrite && mwb_wreg == r) return mwb_result;
    return v;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_ill = 0; m_rw = 0; m_src = 0; m_ctl = 3'b010;
    m_wreg = 0; m_rs = 0; m_rt = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;
  endtask

  task automatic tick();
    logic [3:0] d;
    @(posedge clk);
    if (rst || flush) begin
      model_clear();
    end else if (!stall) begin
      d = ref_dec(id_aluop, id_funct, id_valid);
      m_valid = id_valid; m_ctl = d[3:1]; m_ill = d[0];
      m_wreg = id_regdst ? id_rd : id_rt;
      m_rw = id_regwrite & id_valid;
      m_rs = id_rs; m_rt = id_rt; m_rsd = id_rs_data; m_rtd = id_rt_data;
      m_imm = id_imm; m_src = id_alusrc;
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, " ex_valid"}, ex_valid, m_valid);
    chk({tag, " ctl"}, ctl, m_ctl);
    chk({tag, " ex_illegal"}, ex_illegal, m_ill);
    chk({tag, " ex_wreg"}, ex_wreg, m_wreg);
    chk({tag, " ex_regwrite"}, ex_regwrite, m_rw);
    chk({tag, " dataA"}, dataA, ref_fwd(m_rs, m_rsd));
    chk({tag, " dataB"}, dataB, m_src ? m_imm : ref_fwd(m_rt, m_rtd));
    chk({tag, " ex_store_data"}, ex_store_data, ref_fwd(m_rt, m_rtd));
  endtask

  task automatic randomize_id();
    id_valid = 1'($urandom); id_aluop = 2'($urandom); id_alusrc = 1'($urandom);
    id_funct = ($urandom_range(0, 1) == 0) ? 6'($urandom) : 6'(32 + 2 * $urandom_range(0, 5));
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
    id_rd = 5'($urandom_range(0, 7));
    id_regdst = 1'($urandom); id_regwrite = 1'($urandom);
  endtask

  task automatic randomize_fwd();
    exm_regwrite = 1'($urandom); exm_wreg = 5'($urandom_range(0, 7)); exm_result = $urandom;
    mwb_regwrite = 1'($urandom); mwb_wreg = 5'($urandom_range(0, 7)); mwb_result = $urandom;
  endtask

  typedef struct {
    logic [1:0] aluop;
    logic [5:0] funct;
    logic       valid;
    logic [2:0] ctl;
    logic       ill;
  } dec_vec_t;

  dec_vec_t tbl[12];

  initial begin
    tbl[0]  = '{2'b00, 6'd7,  1'b1, 3'b010, 1'b0};
    tbl[1]  = '{2'b01, 6'd32, 1'b1, 3'b110, 1'b0};
    tbl[2]  = '{2'b11, 6'd42, 1'b1, 3'b001, 1'b0};
    tbl[3]  = '{2'b10, 6'd32, 1'b1, 3'b010, 1'b0};
    tbl[4]  = '{2'b10, 6'd34, 1'b1, 3'b110, 1'b0};
    tbl[5]  = '{2'b10, 6'd36, 1'b1, 3'b000, 1'b0};
    tbl[6]  = '{2'b10, 6'd37, 1'b1, 3'b001, 1'b0};
    tbl[7]  = '{2'b10, 6'd42, 1'b1, 3'b111, 1'b0};
    tbl[8]  = '{2'b10, 6'd7,  1'b1, 3'b010, 1'b1};
    tbl[9]  = '{2'b10, 6'd7,  1'b0, 3'b010, 1'b0};
    tbl[10] = '{2'b10, 6'd33, 1'b1, 3'b010, 1'b1};
    tbl[11] = '{2'b10, 6'd36, 1'b0, 3'b000, 1'b0};

    rst = 1; stall = 0; flush = 0;
    id_valid = 0; id_aluop = 0; id_funct = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_alusrc = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_regdst = 0; id_regwrite = 0;
    exm_regwrite = 0; exm_wreg = 0; exm_result = 0;
    mwb_regwrite = 0; mwb_wreg = 0; mwb_result = 0;
    model_clear();

    // Reset state
    tick();
    chk("reset ex_valid", ex_valid, 0);
    chk("reset ctl", ctl, 3'b010);
    chk("reset ex_wreg", ex_wreg, 0);
    check_all("reset");
    rst = 0;

    // R-type add
    id_valid = 1; id_aluop = 2'b10; id_funct = 6'b100000; id_rs_data = 5; id_rt_data = 7;
    id_rs = 1; id_rt = 9; id_rd = 3; id_regdst = 1; id_regwrite = 1;
    tick();
    chk("add ctl", ctl, 3'b010);
    chk("add dataA", dataA, 5);
    chk("add dataB", dataB, 7);
    chk("add ex_wreg", ex_wreg, 3);
    chk("add ex_regwrite", ex_regwrite, 1);

    // Forward priority on rs=4
    id_rs = 4; id_rs_data = 32'h99;
    tick();
    exm_regwrite = 1; exm_wreg = 4; exm_result = 32'h11;
    mwb_regwrite = 1; mwb_wreg = 4; mwb_result = 32'h22;
    #1;
    chk("fwd exm wins", dataA, FWD ? 32'h11 : 32'h99);
    exm_regwrite = 0;
    #1;
    chk("fwd mwb", dataA, FWD ? 32'h22 : 32'h99);
    id_rs = 0; id_rs_data = 32'h55;
    exm_regwrite = 1; exm_wreg = 0; mwb_wreg = 0;
    tick();
    chk("fwd r0 blocked", dataA, 32'h55);

    // sw with rt forwarded from MEM/WB
    id_aluop = 2'b00; id_alusrc = 1; id_imm = 32'hFFFF_FFFC; id_rt = 2; id_rt_data = 32'h1234;
    id_regdst = 0; id_regwrite = 0;
    exm_regwrite = 0; mwb_regwrite = 1; mwb_wreg = 2; mwb_result = 32'hABCD;
    tick();
    chk("sw dataB", dataB, 32'hFFFF_FFFC);
    chk("sw store", ex_store_data, FWD ? 32'hABCD : 32'h1234);
    chk("sw ctl", ctl, 3'b010);

    // Stall 3 cycles while ID changes
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      randomize_id();
      tick();
      chk($sformatf("stall%0d dataB", i), dataB, 32'hFFFF_FFFC);
      chk($sformatf("stall%0d ex_wreg", i), ex_wreg, 2);
      chk($sformatf("stall%0d ex_valid", i), ex_valid, 1);
      chk($sformatf("stall%0d store", i), ex_store_data, FWD ? 32'hABCD : 32'h1234);
      check_all($sformatf("stall%0d", i));
    end
    flush = 1; id_valid = 1; id_regwrite = 1; id_aluop = 2'b01;
    tick();
    chk("stall+flush ex_valid", ex_valid, 0);
    chk("stall+flush ex_regwrite", ex_regwrite, 0);
    chk("stall+flush ctl", ctl, 3'b010);
    stall = 0; flush = 0;

    // Decode table
    for (int i = 0; i < 12; i++) begin
      id_aluop = tbl[i].aluop; id_funct = tbl[i].funct; id_valid = tbl[i].valid;
      tick();
      chk($sformatf("dec%0d ctl", i), ctl, tbl[i].ctl);
      chk($sformatf("dec%0d ex_illegal", i), ex_illegal, tbl[i].ill);
    end

    // Reset mid-stream overrides stall
    id_valid = 1; id_regwrite = 1; id_regdst = 1; id_rd = 7; id_rs = 3; id_rt = 5;
    id_rs_data = 32'hDEAD; id_rt_data = 32'hBEEF; id_aluop = 2'b10; id_funct = 6'd7;
    id_alusrc = 0; exm_regwrite = 0; mwb_regwrite = 0;
    tick();
    chk("pre-rst ex_valid", ex_valid, 1);
    rst = 1; stall = 1;
    tick();
    chk("midrst ex_valid", ex_valid, 0);
    chk("midrst ctl", ctl, 3'b010);
    chk("midrst ex_wreg", ex_wreg, 0);
    chk("midrst ex_regwrite", ex_regwrite, 0);
    chk("midrst ex_illegal", ex_illegal, 0);
    chk("midrst dataA", dataA, 0);
    chk("midrst dataB", dataB, 0);
    chk("midrst store", ex_store_data, 0);
    rst = 0; stall = 0;

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 31) == 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 5) == 0);
      randomize_id();
      randomize_fwd();
      tick();
      check_all($sformatf("rnd%0d", i));
      randomize_fwd();
      #1;
      check_all($sformatf("rnd%0d comb", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that feeds the 32-bit `alu` block. It registers decoded instruction fields and operands from decode, and translates ALUOp/funct into the ALU's 3-bit `ctl` code. It resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and drives `dataA`/`dataB` straight into the ALU. It also supports stall (hold) and flush (bubble) from the hazard unit.

## Interface
- `DATA_W`, 32, operand/result width
- `clk` in 1: sole clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `stall` in 1: hold all stage registers
- `flush` in 1: load a bubble
- `id_valid` in 1: decode slot holds an instruction
- `id_aluop` in 2: 00 add (lw/sw), 01 sub (beq), 10 R-type per funct, 11 or (ori)
- `id_funct` in 6: R-type funct field
- `id_rs_data`, `id_rt_data` in DATA_W: register-file read data
- `id_imm` in DATA_W: sign/zero-extended immediate
- `id_alusrc` in 1: 1 selects immediate for B
- `id_rs`, `id_rt`, `id_rd` in 5 each: register numbers
- `id_regdst` in 1: 1 selects `rd` as destination, 0 selects `rt`
- `id_regwrite` in 1: instruction writes the register file
- `exm_regwrite` in 1, `exm_wreg` in 5, `exm_result` in DATA_W: EX/MEM forward source
- `mwb_regwrite` in 1, `mwb_wreg` in 5, `mwb_result` in DATA_W: MEM/WB forward source
- `ex_valid` out 1: stage holds a live instruction
- `ctl` out 3: ALU control, registered
- `dataA`, `dataB` out DATA_W: ALU operands, after forwarding
- `ex_store_data` out DATA_W: forwarded rt value for sw
- `ex_wreg` out 5: destination register
- `ex_regwrite` out 1: gated by `ex_valid`
- `ex_illegal` out 1: unsupported R-type funct latched

## Operation
- Each rising edge, priority order:
  - `rst`: all registers take their reset values.
  - else `flush`: bubble.
  - else `stall`: hold.
  - else load all ID fields.
- Reset and bubble values:
  - `ex_valid`=0, `ex_regwrite`=0, `ex_illegal`=0
  - `ctl`=3'b010, `ex_wreg`=0
  - all data/number registers 0
- `ctl` decode, registered with the fields:
  - aluop 00 → 010; aluop 01 → 110; aluop 11 → 001.
  - aluop 10 by funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111.
  - Any other funct: `ctl`=010 and `ex_illegal`=`id_valid`.
- `ex_wreg` = `id_regdst` ? `id_rd` : `id_rt`, registered.
- `ex_regwrite` = registered (`id_regwrite` & `id_valid`).
- Forwarding is combinational on the registered rs/rt numbers. For each of rs and rt:
  - If `exm_regwrite` and `exm_wreg` ≠ 0 and `exm_wreg` matches → `exm_result`.
  - Else if `mwb_regwrite` and `mwb_wreg` ≠ 0 and `mwb_wreg` matches → `mwb_result`.
  - Else the registered value.
  - EX/MEM always wins over MEM/WB.
- Register 0 is never forwarded.
- Operand outputs:
  - `dataA` = forwarded rs.
  - `dataB` = registered `alusrc` ? registered imm : forwarded rt.
  - `ex_store_data` = forwarded rt, regardless of `alusrc`.
- Outputs reflect forwarding even when `ex_valid`=0; downstream qualifies with `ex_valid`.

## Timing
- Latency: ID inputs appear on the registered outputs 1 cycle after the capturing edge.
- Forward paths are same-cycle combinational (exm/mwb → `dataA`/`dataB`), with no extra register.
- Stall held N cycles: outputs frozen for N cycles. Forward sources may still change `dataA`/`dataB` during a stall.
- `stall` and `flush` both high: flush wins, so a bubble is loaded.
- `rst` asserted mid-stream: reset values at the next edge. `stall`/`flush` are ignored while `rst`=1.
- Back-to-back flushes: `ex_valid` stays 0.

## Configuration
- `ID_EX_FORWARD_EN` defined: forwarding muxes present as described.
- `ID_EX_FORWARD_EN` undefined:
  - `dataA` = registered rs data, and rt uses the registered rt data.
  - exm/mwb inputs are unused; the hazard unit must stall instead.
  - All other behaviour is identical.

## Structure
- Shared package `alu_pkg`:
  - ctl constants `CTL_AND`=000, `CTL_OR`=001, `CTL_ADD`=010, `CTL_SUB`=110, `CTL_SLT`=111
  - ALUOp constants and funct constants (32, 34, 36, 37, 42)
- Sub-module `alu_ctl_dec`: combinational aluop/funct → ctl/illegal. Reused by any future single-cycle datapath.
- Forward mux is inline in `id_ex_stage`.

## Test plan
- Reset, then R-type add: aluop=10, funct=100000, rs_data=5, rt_data=7, regdst=1, rd=3.
  - Next cycle: `ctl`=010, `dataA`=5, `dataB`=7, `ex_wreg`=3, `ex_regwrite`=1.
- EX/MEM and MEM/WB forward on the same register: staged rs=4, exm(1, 4, 0x11), mwb(1, 4, 0x22) → `dataA`=0x11.
  - Drop `exm_regwrite` → `dataA`=0x22.
  - `exm_wreg`=0 with rs=0 → no forward.
- sw: alusrc=1, imm=0xFFFFFFFC, rt=2 forwarded from mwb=0xABCD → `dataB`=0xFFFFFFFC, `ex_store_data`=0xABCD, `ctl`=010.
- Stall 3 cycles while ID inputs change → outputs unchanged for 3 cycles. Then `stall`+`flush` together → `ex_valid`=0, `ex_regwrite`=0, `ctl`=010.
- Illegal funct: funct=000111, aluop=10, id_valid=1 → `ex_illegal`=1, `ctl`=010. Same with id_valid=0 → `ex_illegal`=0.
- Reset mid-stream: `rst` asserted with `stall`=1 and valid data staged → all outputs at reset values next cycle.
